// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : ALU function codes, forward-select encoding and datapath defaults
// Rev    : 1.0
// ============================================================================
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int SHAMT_W    = 5;
  localparam int ALUFUN_W   = 6;

  typedef enum logic [ALUFUN_W-1:0] {
    ALU_ADD = 6'b000000,
    ALU_SUB = 6'b000001,
    ALU_AND = 6'b011000,
    ALU_OR  = 6'b011110,
    ALU_XOR = 6'b010110,
    ALU_NOR = 6'b010001,
    ALU_A   = 6'b011010,
    ALU_SLL = 6'b100000,
    ALU_SRL = 6'b100001,
    ALU_SRA = 6'b100011,
    ALU_EQ  = 6'b110011,
    ALU_NEQ = 6'b110001,
    ALU_LT  = 6'b110101,
    ALU_LEZ = 6'b111101,
    ALU_LTZ = 6'b111011,
    ALU_GTZ = 6'b111111
  } alu_fun_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module : id_ex_operand_stage_if
// Brief  : ID-side, forwarding and ALU-side signals of the ID/EX operand stage
// Rev    : 1.0
// ============================================================================
interface id_ex_operand_stage_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) ();

  logic                iValid;
  logic [DATA_W-1:0]   iRsData;
  logic [DATA_W-1:0]   iRtData;
  logic [REG_AW-1:0]   iRsAddr;
  logic [REG_AW-1:0]   iRtAddr;
  logic [DATA_W-1:0]   iImm;
  logic [SHAMT_W-1:0]  iShamt;
  logic                iSrcA;
  logic                iSrcB;
  logic [ALUFUN_W-1:0] iALUFun;
  logic                iSign;
  logic [REG_AW-1:0]   iWrAddr;
  logic                iRegWrite;
  logic                iMemRead;
  logic                iStall;
  logic                iFlush;
  logic                iExMemRegWrite;
  logic [REG_AW-1:0]   iExMemWrAddr;
  logic [DATA_W-1:0]   iExMemData;
  logic                iMemWbRegWrite;
  logic [REG_AW-1:0]   iMemWbWrAddr;
  logic [DATA_W-1:0]   iMemWbData;

  logic [DATA_W-1:0]   oA;
  logic [DATA_W-1:0]   oB;
  logic [ALUFUN_W-1:0] oALUFun;
  logic                oSign;
  logic [DATA_W-1:0]   oRtFwd;
  logic [REG_AW-1:0]   oWrAddr;
  logic                oRegWrite;
  logic                oMemRead;
  logic                oValid;
  logic                oLoadUse;

  modport master (
    output iValid, iRsData, iRtData, iRsAddr, iRtAddr, iImm, iShamt, iSrcA, iSrcB,
           iALUFun, iSign, iWrAddr, iRegWrite, iMemRead, iStall, iFlush,
           iExMemRegWrite, iExMemWrAddr, iExMemData,
           iMemWbRegWrite, iMemWbWrAddr, iMemWbData,
    input  oA, oB, oALUFun, oSign, oRtFwd, oWrAddr, oRegWrite, oMemRead, oValid, oLoadUse
  );

  modport slave (
    input  iValid, iRsData, iRtData, iRsAddr, iRtAddr, iImm, iShamt, iSrcA, iSrcB,
           iALUFun, iSign, iWrAddr, iRegWrite, iMemRead, iStall, iFlush,
           iExMemRegWrite, iExMemWrAddr, iExMemData,
           iMemWbRegWrite, iMemWbWrAddr, iMemWbData,
    output oA, oB, oALUFun, oSign, oRtFwd, oWrAddr, oRegWrite, oMemRead, oValid, oLoadUse
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module : fwd_mux
// Brief  : Priority forwarding select for one operand (EX/MEM over MEM/WB)
// Rev    : 1.0
// ============================================================================
module fwd_mux
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] iAddr,
  input  logic [DATA_W-1:0] iRegData,
  input  logic              iExMemRegWrite,
  input  logic [REG_AW-1:0] iExMemWrAddr,
  input  logic [DATA_W-1:0] iExMemData,
  input  logic              iMemWbRegWrite,
  input  logic [REG_AW-1:0] iMemWbWrAddr,
  input  logic [DATA_W-1:0] iMemWbData,
  output logic [DATA_W-1:0] oData
);

  fwd_sel_e wSel;

  // Register 0 is hard-wired zero, so it never takes a forwarded value.
  always_comb begin
    wSel = FWD_REG;
    if (iAddr != '0) begin
      if (iExMemRegWrite && (iExMemWrAddr == iAddr))
        wSel = FWD_EXMEM;
      else if (iMemWbRegWrite && (iMemWbWrAddr == iAddr))
        wSel = FWD_MEMWB;
    end
  end

  always_comb begin
    case (wSel)
      FWD_EXMEM: oData = iExMemData;
      FWD_MEMWB: oData = iMemWbData;
      default:   oData = iRegData;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : id_ex_operand_stage
// Brief  : ID/EX register with operand forwarding and load-use detection
// Rev    : 1.0
// ============================================================================
module id_ex_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                 iClk,
  input  logic                 iRst,
  id_ex_operand_stage_if.slave bus
);

  logic                rValid;
  logic                rRegWrite;
  logic                rMemRead;
  logic                rSign;
  logic                rSrcA;
  logic                rSrcB;
  logic [ALUFUN_W-1:0] rALUFun;
  logic [REG_AW-1:0]   rWrAddr;
  logic [REG_AW-1:0]   rRsAddr;
  logic [REG_AW-1:0]   rRtAddr;
  logic [DATA_W-1:0]   rRsData;
  logic [DATA_W-1:0]   rRtData;
  logic [DATA_W-1:0]   rImm;
  logic [SHAMT_W-1:0]  rShamt;

  logic [DATA_W-1:0]   wFwdRs;
  logic [DATA_W-1:0]   wFwdRt;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) uFwdRs (
    .iAddr          (rRsAddr),
    .iRegData       (rRsData),
    .iExMemRegWrite (bus.iExMemRegWrite),
    .iExMemWrAddr   (bus.iExMemWrAddr),
    .iExMemData     (bus.iExMemData),
    .iMemWbRegWrite (bus.iMemWbRegWrite),
    .iMemWbWrAddr   (bus.iMemWbWrAddr),
    .iMemWbData     (bus.iMemWbData),
    .oData          (wFwdRs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) uFwdRt (
    .iAddr          (rRtAddr),
    .iRegData       (rRtData),
    .iExMemRegWrite (bus.iExMemRegWrite),
    .iExMemWrAddr   (bus.iExMemWrAddr),
    .iExMemData     (bus.iExMemData),
    .iMemWbRegWrite (bus.iMemWbRegWrite),
    .iMemWbWrAddr   (bus.iMemWbWrAddr),
    .iMemWbData     (bus.iMemWbData),
    .oData          (wFwdRt)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rValid    <= 1'b0;
      rRegWrite <= 1'b0;
      rMemRead  <= 1'b0;
      rSign     <= 1'b0;
      rSrcA     <= 1'b0;
      rSrcB     <= 1'b0;
      rALUFun   <= ALU_ADD;
      rWrAddr   <= '0;
      rRsAddr   <= '0;
      rRtAddr   <= '0;
      rRsData   <= '0;
      rRtData   <= '0;
      rImm      <= '0;
      rShamt    <= '0;
    end else if (bus.iFlush) begin
      rValid    <= 1'b0;
      rRegWrite <= 1'b0;
      rMemRead  <= 1'b0;
    end else if (bus.iStall) begin
      // Capture forwarded operands so a producer retiring mid-stall is not lost.
      rRsData   <= wFwdRs;
      rRtData   <= wFwdRt;
    end else begin
      rValid    <= bus.iValid;
      rRegWrite <= bus.iRegWrite & bus.iValid;
      rMemRead  <= bus.iMemRead & bus.iValid;
      rSign     <= bus.iSign;
      rSrcA     <= bus.iSrcA;
      rSrcB     <= bus.iSrcB;
      rALUFun   <= bus.iALUFun;
      rWrAddr   <= bus.iWrAddr;
      rRsAddr   <= bus.iRsAddr;
      rRtAddr   <= bus.iRtAddr;
      rRsData   <= bus.iRsData;
      rRtData   <= bus.iRtData;
      rImm      <= bus.iImm;
      rShamt    <= bus.iShamt;
    end
  end

  assign bus.oA        = rSrcA ? {{(DATA_W-SHAMT_W){1'b0}}, rShamt} : wFwdRs;
  assign bus.oB        = rSrcB ? rImm : wFwdRt;
  assign bus.oRtFwd    = wFwdRt;
  assign bus.oALUFun   = rALUFun;
  assign bus.oSign     = rSign;
  assign bus.oWrAddr   = rWrAddr;
  assign bus.oRegWrite = rRegWrite & rValid;
  assign bus.oMemRead  = rMemRead & rValid;
  assign bus.oValid    = rValid;

  assign bus.oLoadUse  = rValid & rMemRead & (rWrAddr != '0) & bus.iValid &
                         ((rWrAddr == bus.iRsAddr) | (rWrAddr == bus.iRtAddr));

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_id_ex_operand_stage
// Brief  : Directed and randomized checks of the ID/EX operand stage
// Rev    : 1.0
// ============================================================================
module tb_id_ex_operand_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  // Reference state: what the stage is supposed to hold.
  logic        mValid, mRegWrite, mMemRead, mSign, mSrcA, mSrcB;
  logic [5:0]  mALUFun;
  logic [4:0]  mWrAddr, mRsAddr, mRtAddr, mShamt;
  logic [31:0] mRsData, mRtData, mImm;

  function automatic logic [31:0] fwdVal(input logic [4:0] a, input logic [31:0] d);
    if (a != 0 && bus.iExMemRegWrite && bus.iExMemWrAddr == a) return bus.iExMemData;
    if (a != 0 && bus.iMemWbRegWrite && bus.iMemWbWrAddr == a) return bus.iMemWbData;
    return d;
  endfunction

  task automatic modelReset();
    {mValid, mRegWrite, mMemRead, mSign, mSrcA, mSrcB} = '0;
    mALUFun = 0; mWrAddr = 0; mRsAddr = 0; mRtAddr = 0; mShamt = 0;
    mRsData = 0; mRtData = 0; mImm = 0;
  endtask

  task automatic idle();
    bus.iValid = 0; bus.iRsData = 0; bus.iRtData = 0; bus.iRsAddr = 0; bus.iRtAddr = 0;
    bus.iImm = 0; bus.iShamt = 0; bus.iSrcA = 0; bus.iSrcB = 0; bus.iALUFun = 0;
    bus.iSign = 0; bus.iWrAddr = 0; bus.iRegWrite = 0; bus.iMemRead = 0;
    bus.iStall = 0; bus.iFlush = 0;
    bus.iExMemRegWrite = 0; bus.iExMemWrAddr = 0; bus.iExMemData = 0;
    bus.iMemWbRegWrite = 0; bus.iMemWbWrAddr = 0; bus.iMemWbData = 0;
  endtask

  // One rising edge; the model follows flush > stall > load.
  task automatic tick();
    logic [31:0] nRs, nRt;
    nRs = fwdVal(mRsAddr, mRsData);
    nRt = fwdVal(mRtAddr, mRtData);
    @(posedge clk);
    if (rst) modelReset();
    else if (bus.iFlush) begin
      mValid = 0; mRegWrite = 0; mMemRead = 0;
    end else if (bus.iStall) begin
      mRsData = nRs; mRtData = nRt;
    end else begin
      mValid = bus.iValid; mRegWrite = bus.iRegWrite; mMemRead = bus.iMemRead;
      mSign = bus.iSign; mSrcA = bus.iSrcA; mSrcB = bus.iSrcB; mALUFun = bus.iALUFun;
      mWrAddr = bus.iWrAddr; mRsAddr = bus.iRsAddr; mRtAddr = bus.iRtAddr;
      mRsData = bus.iRsData; mRtData = bus.iRtData; mImm = bus.iImm; mShamt = bus.iShamt;
    end
    #1;
  endtask

  task automatic loadInstr(input logic [5:0] fun, input logic [4:0] rsA, input logic [31:0] rsD,
                           input logic [4:0] rtA, input logic [31:0] rtD, input logic [4:0] wa,
                           input logic rw, input logic mr);
    bus.iValid = 1; bus.iALUFun = fun; bus.iRsAddr = rsA; bus.iRsData = rsD;
    bus.iRtAddr = rtA; bus.iRtData = rtD; bus.iWrAddr = wa; bus.iRegWrite = rw;
    bus.iMemRead = mr; bus.iSrcA = 0; bus.iSrcB = 0; bus.iShamt = 0; bus.iImm = 0;
    tick();
  endtask

  task automatic test_reset();
    idle(); modelReset(); rst = 1; #2;
    total++;
    if (bus.oValid !== 0 || bus.oRegWrite !== 0 || bus.oMemRead !== 0) begin
      bad++; $display("FAIL reset_ctrl: valid/rw/mr=%b%b%b expected 000", bus.oValid, bus.oRegWrite, bus.oMemRead);
    end
    total++;
    if (bus.oA !== 0 || bus.oB !== 0 || bus.oRtFwd !== 0 || bus.oALUFun !== 0 || bus.oWrAddr !== 0) begin
      bad++; $display("FAIL reset_data: A=%h B=%h Rt=%h fun=%h wa=%h expected all 0",
                      bus.oA, bus.oB, bus.oRtFwd, bus.oALUFun, bus.oWrAddr);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_load_add();
    loadInstr(ALU_ADD, 5'd1, 32'd7, 5'd2, 32'd8, 5'd9, 1'b1, 1'b0);
    idle(); #1;
    total++;
    if (bus.oA !== 32'd7 || bus.oB !== 32'd8 || bus.oALUFun !== 6'd0 || bus.oValid !== 1'b1) begin
      bad++; $display("FAIL load_add: A=%0d B=%0d fun=%h valid=%b expected 7 8 00 1",
                      bus.oA, bus.oB, bus.oALUFun, bus.oValid);
    end
    rst = 1; modelReset(); #1;
    total++;
    if (bus.oA !== 0 || bus.oB !== 0 || bus.oValid !== 0 || bus.oRegWrite !== 0) begin
      bad++; $display("FAIL async_reset: A=%h B=%h valid=%b rw=%b expected 0", bus.oA, bus.oB, bus.oValid, bus.oRegWrite);
    end
    #1 rst = 0;
  endtask

  task automatic test_shift();
    bus.iValid = 1; bus.iALUFun = ALU_SLL; bus.iShamt = 5'd4; bus.iSrcA = 1; bus.iSrcB = 0;
    bus.iRsAddr = 5'd0; bus.iRtAddr = 5'd10; bus.iRtData = 32'h800000D9; bus.iRsData = 32'hDEAD;
    tick(); idle(); #1;
    total++;
    if (bus.oA !== 32'd4 || bus.oB !== 32'h800000D9 || bus.oALUFun !== ALU_SLL) begin
      bad++; $display("FAIL shift_sel: A=%h B=%h fun=%h expected 4 800000d9 20", bus.oA, bus.oB, bus.oALUFun);
    end
  endtask

  task automatic test_fwd_priority();
    loadInstr(ALU_OR, 5'd3, 32'h99, 5'd4, 32'h44, 5'd6, 1'b1, 1'b0);
    idle();
    bus.iExMemRegWrite = 1; bus.iExMemWrAddr = 3; bus.iExMemData = 32'h11;
    bus.iMemWbRegWrite = 1; bus.iMemWbWrAddr = 3; bus.iMemWbData = 32'h22; #1;
    total++;
    if (bus.oA !== 32'h11) begin bad++; $display("FAIL fwd_exmem_wins: A=%h expected 11", bus.oA); end
    bus.iExMemRegWrite = 0; #1;
    total++;
    if (bus.oA !== 32'h22) begin bad++; $display("FAIL fwd_memwb: A=%h expected 22", bus.oA); end
    bus.iExMemRegWrite = 1; bus.iExMemWrAddr = 4; bus.iMemWbRegWrite = 0; #1;
    total++;
    if (bus.oRtFwd !== 32'h11 || bus.oB !== 32'h11) begin
      bad++; $display("FAIL fwd_rt: Rt=%h B=%h expected 11 11", bus.oRtFwd, bus.oB);
    end
    idle();
    loadInstr(ALU_OR, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 1'b1, 1'b0);
    idle();
    bus.iExMemRegWrite = 1; bus.iExMemWrAddr = 0; bus.iExMemData = 32'h11;
    bus.iMemWbRegWrite = 1; bus.iMemWbWrAddr = 0; bus.iMemWbData = 32'h22; #1;
    total++;
    if (bus.oA !== 0 || bus.oB !== 0) begin bad++; $display("FAIL fwd_zero_reg: A=%h B=%h expected 0 0", bus.oA, bus.oB); end
    idle();
  endtask

  task automatic test_stall_relatch();
    loadInstr(ALU_AND, 5'd7, 32'h70, 5'd6, 32'h10, 5'd12, 1'b1, 1'b0);
    idle(); bus.iStall = 1;
    bus.iMemWbRegWrite = 1; bus.iMemWbWrAddr = 6; bus.iMemWbData = 32'h55; #1;
    total++;
    if (bus.oB !== 32'h55) begin bad++; $display("FAIL stall_c1: B=%h expected 55", bus.oB); end
    for (int c = 2; c <= 3; c++) begin
      tick();
      bus.iMemWbRegWrite = 0; bus.iRtData = 32'hBAD0 + c; bus.iALUFun = ALU_XOR; bus.iValid = 1; #1;
      total++;
      if (bus.oB !== 32'h55 || bus.oRtFwd !== 32'h55) begin
        bad++; $display("FAIL stall_c%0d: B=%h Rt=%h expected 55", c, bus.oB, bus.oRtFwd);
      end
      total++;
      if (bus.oALUFun !== ALU_AND || bus.oValid !== 1 || bus.oRegWrite !== 1 || bus.oWrAddr !== 5'd12 || bus.oA !== 32'h70) begin
        bad++; $display("FAIL stall_ctrl_c%0d: fun=%h v=%b rw=%b wa=%0d A=%h expected 18 1 1 12 70",
                        c, bus.oALUFun, bus.oValid, bus.oRegWrite, bus.oWrAddr, bus.oA);
      end
    end
    idle();
  endtask

  task automatic test_flush_vs_stall();
    loadInstr(ALU_ADD, 5'd1, 32'h1, 5'd2, 32'h2, 5'd8, 1'b1, 1'b1);
    idle(); bus.iFlush = 1; bus.iStall = 1; bus.iValid = 1; bus.iRegWrite = 1; bus.iMemRead = 1;
    tick(); idle(); #1;
    total++;
    if (bus.oValid !== 0 || bus.oRegWrite !== 0 || bus.oMemRead !== 0) begin
      bad++; $display("FAIL flush_wins: v/rw/mr=%b%b%b expected 000", bus.oValid, bus.oRegWrite, bus.oMemRead);
    end
  endtask

  task automatic test_load_use();
    loadInstr(ALU_ADD, 5'd1, 32'h0, 5'd2, 32'h0, 5'd5, 1'b1, 1'b1);
    idle(); bus.iValid = 1; bus.iRsAddr = 9; bus.iRtAddr = 5; #1;
    total++;
    if (bus.oLoadUse !== 1) begin bad++; $display("FAIL load_use_rt: got %b expected 1", bus.oLoadUse); end
    bus.iValid = 0; #1;
    total++;
    if (bus.oLoadUse !== 0) begin bad++; $display("FAIL load_use_idvalid: got %b expected 0", bus.oLoadUse); end
    loadInstr(ALU_ADD, 5'd1, 32'h0, 5'd2, 32'h0, 5'd0, 1'b1, 1'b1);
    idle(); bus.iValid = 1; bus.iRsAddr = 0; bus.iRtAddr = 0; #1;
    total++;
    if (bus.oLoadUse !== 0) begin bad++; $display("FAIL load_use_dest0: got %b expected 0", bus.oLoadUse); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] eRs, eRt, eA, eB;
    logic        eLU;
    for (int n = 0; n < 400; n++) begin
      bus.iValid = 1'($urandom); bus.iRsData = $urandom; bus.iRtData = $urandom;
      bus.iRsAddr = 5'($urandom_range(0, 7)); bus.iRtAddr = 5'($urandom_range(0, 7));
      bus.iImm = $urandom; bus.iShamt = 5'($urandom); bus.iSrcA = 1'($urandom); bus.iSrcB = 1'($urandom);
      bus.iALUFun = 6'($urandom); bus.iSign = 1'($urandom); bus.iWrAddr = 5'($urandom_range(0, 7));
      bus.iRegWrite = 1'($urandom); bus.iMemRead = 1'($urandom);
      bus.iStall = ($urandom_range(0, 3) == 0); bus.iFlush = ($urandom_range(0, 5) == 0);
      bus.iExMemRegWrite = 1'($urandom); bus.iExMemWrAddr = 5'($urandom_range(0, 7)); bus.iExMemData = $urandom;
      bus.iMemWbRegWrite = 1'($urandom); bus.iMemWbWrAddr = 5'($urandom_range(0, 7)); bus.iMemWbData = $urandom;
      #1;
      eRs = fwdVal(mRsAddr, mRsData);
      eRt = fwdVal(mRtAddr, mRtData);
      eA  = mSrcA ? 32'(mShamt) : eRs;
      eB  = mSrcB ? mImm : eRt;
      eLU = mValid && mMemRead && mWrAddr != 0 && bus.iValid &&
            (mWrAddr == bus.iRsAddr || mWrAddr == bus.iRtAddr);
      total++;
      if (bus.oA !== eA) begin bad++; $display("FAIL rnd_A[%0d]: got %h expected %h", n, bus.oA, eA); end
      total++;
      if (bus.oB !== eB) begin bad++; $display("FAIL rnd_B[%0d]: got %h expected %h", n, bus.oB, eB); end
      total++;
      if (bus.oRtFwd !== eRt) begin bad++; $display("FAIL rnd_RtFwd[%0d]: got %h expected %h", n, bus.oRtFwd, eRt); end
      total++;
      if (bus.oALUFun !== mALUFun || bus.oSign !== mSign || bus.oWrAddr !== mWrAddr) begin
        bad++; $display("FAIL rnd_ctrl[%0d]: fun=%h sign=%b wa=%0d expected %h %b %0d",
                        n, bus.oALUFun, bus.oSign, bus.oWrAddr, mALUFun, mSign, mWrAddr);
      end
      total++;
      if (bus.oValid !== mValid || bus.oRegWrite !== (mRegWrite & mValid) || bus.oMemRead !== (mMemRead & mValid)) begin
        bad++; $display("FAIL rnd_flags[%0d]: v/rw/mr=%b%b%b expected %b%b%b", n, bus.oValid, bus.oRegWrite,
                        bus.oMemRead, mValid, mRegWrite & mValid, mMemRead & mValid);
      end
      total++;
      if (bus.oLoadUse !== eLU) begin bad++; $display("FAIL rnd_loaduse[%0d]: got %b expected %b", n, bus.oLoadUse, eLU); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_shift();
    test_fwd_priority();
    test_stall_relatch();
    test_flush_vs_stall();
    test_load_use();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
